// File: rtl/eq_coeff_ctrl_pkg.sv
// Shared definitions for the equalizer coefficient store: per-band coefficient layout,
// fixed-point format and the controller state encoding.
package eq_coeff_ctrl_pkg;

  // Coefficients per biquad band, stored in the order A0, A1, A2, -B1, -B2.
  localparam int unsigned NrEqBandCoeff = 5;

  typedef enum int unsigned {
    CoeffA0 = 0,
    CoeffA1 = 1,
    CoeffA2 = 2,
    CoeffB1 = 3,
    CoeffB2 = 4
  } coeff_off_e;

  // Integer bits above the sign bit; unity sits at bit (width - 1 - CoeffHeadroom).
  localparam int unsigned CoeffHeadroom = 3;

  typedef enum logic [1:0] {
    StSync,
    StIdle,
    StWaitSwap,
    StCopy
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // True for the A0 slot of a band, the only non-zero word of a passthrough set.
  function automatic logic is_a0(input int unsigned addr);
    return (addr % NrEqBandCoeff) == int'(CoeffA0);
  endfunction

endpackage

// File: rtl/eq_coeff_bank.sv
// One coefficient bank: distributed RAM with a synchronous write port and two
// asynchronous read ports (a: equalizer, b: copy source).
module eq_coeff_bank
  import eq_coeff_ctrl_pkg::*;
#(
  parameter int unsigned Depth = 160,
  parameter int unsigned Width = 32,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_a_i,
  output logic [Width-1:0] rdata_a_o,
  input  logic [AddrW-1:0] raddr_b_i,
  output logic [Width-1:0] rdata_b_o
);

  localparam logic [Width-1:0] Unity = Width'(1) << (Width - 1 - CoeffHeadroom);

  // Words are stored XOR'd with the passthrough pattern, so a RAM that comes up
  // zero-filled at configuration time reads back as a passthrough coefficient set.
  logic [Width-1:0] mem_q [Depth];

  function automatic logic [Width-1:0] init_word(input logic [AddrW-1:0] addr);
    return is_a0(32'(addr)) ? Unity : '0;
  endfunction

  // Synchronous write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i ^ init_word(waddr_i);
    end
  end

  // Equalizer read port; addresses beyond the store read as zero.
  always_comb begin
    rdata_a_o = '0;
    if (32'(raddr_a_i) < Depth) begin
      rdata_a_o = mem_q[raddr_a_i] ^ init_word(raddr_a_i);
    end
  end

  // Copy-source read port; only ever addressed by the in-range copy counter.
  assign rdata_b_o = mem_q[raddr_b_i] ^ init_word(raddr_b_i);

endmodule

// File: rtl/eq_coeff_ctrl.sv
// Double-buffered biquad coefficient store. The equalizer reads the active bank, the host
// writes the shadow bank; a commit swaps banks between samples and then re-syncs the shadow.
module eq_coeff_ctrl
  import eq_coeff_ctrl_pkg::*;
#(
  parameter int unsigned NR_CHANNELS    = 4,
  parameter int unsigned NR_EQ_BANDS    = 8,
  parameter int unsigned EQ_COEFF_WIDTH = 32,
  localparam int unsigned NrEqCoeff     = NR_CHANNELS * NR_EQ_BANDS * NrEqBandCoeff,
  localparam int unsigned AW            = clog2(NrEqCoeff)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [AW-1:0]             eq_coeff_addr_i,
  output logic [EQ_COEFF_WIDTH-1:0] eq_coeff_o,
  input  logic                      eq_idle_i,
  input  logic [AW-1:0]             cfg_wr_addr_i,
  input  logic [EQ_COEFF_WIDTH-1:0] cfg_wr_data_i,
  input  logic                      cfg_wr_i,
  output logic                      cfg_wr_ready_o,
  input  logic                      cfg_commit_i,
  output logic                      cfg_busy_o,
  output logic                      cfg_done_o,
  output logic                      cfg_error_o
);

  localparam int unsigned W = EQ_COEFF_WIDTH;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          copying;
  logic          copy_last;
  logic          wr_acc;
  logic          wr_in_range;
  logic          host_we;
  logic          bank0_we, bank1_we;
  logic [AW-1:0] bank_waddr;
  logic [W-1:0]  bank_wdata;
  logic [W-1:0]  rdata_a0, rdata_a1, rdata_b0, rdata_b1;
  logic [W-1:0]  copy_src;

  assign copy_last   = (cnt_q == AW'(NrEqCoeff - 1));
  assign wr_acc      = cfg_wr_i & cfg_wr_ready_o;
  assign wr_in_range = (32'(cfg_wr_addr_i) < NrEqCoeff);
  assign host_we     = wr_acc & wr_in_range;

  // State register plus counter, bank select and the registered status pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StSync;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      error_q  <= error_d;
    end
  end

  // Next-state logic: copy walk, commit handshake and swap on an idle equalizer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = 1'b0;
    error_d  = 1'b0;
    unique case (state_q)
      StSync, StCopy: begin
        if (copy_last) begin
          cnt_d   = '0;
          state_d = StIdle;
          // Only a host-requested copy reports completion; the post-reset sync is silent.
          done_d  = (state_q == StCopy);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StIdle: begin
        error_d = wr_acc & ~wr_in_range;
        if (cfg_commit_i) begin
          state_d = StWaitSwap;
        end
      end
      StWaitSwap: begin
        if (eq_idle_i) begin
          active_d = ~active_q;
          cnt_d    = '0;
          state_d  = StCopy;
        end
      end
      default: state_d = StSync;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    cfg_wr_ready_o = 1'b0;
    cfg_busy_o     = 1'b1;
    copying        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_wr_ready_o = 1'b1;
        cfg_busy_o     = 1'b0;
      end
      StSync, StCopy: copying = 1'b1;
      StWaitSwap:     copying = 1'b0;
      default:        copying = 1'b0;
    endcase
  end

  assign cfg_done_o  = done_q;
  assign cfg_error_o = error_q;

  // Only the shadow bank is ever written: host data in IDLE, active-bank words when copying.
  // A copy write coinciding with reset is dropped so the copied prefix is well defined.
  assign copy_src   = active_q ? rdata_b1 : rdata_b0;
  assign bank_waddr = copying ? cnt_q : cfg_wr_addr_i;
  assign bank_wdata = copying ? copy_src : cfg_wr_data_i;
  assign bank0_we   = active_q & (host_we | copying) & ~rst_i;
  assign bank1_we   = ~active_q & (host_we | copying) & ~rst_i;

  assign eq_coeff_o = active_q ? rdata_a1 : rdata_a0;

  eq_coeff_bank #(
    .Depth(NrEqCoeff),
    .Width(W),
    .AddrW(AW)
  ) u_bank0 (
    .clk_i    (clk_i),
    .we_i     (bank0_we),
    .waddr_i  (bank_waddr),
    .wdata_i  (bank_wdata),
    .raddr_a_i(eq_coeff_addr_i),
    .rdata_a_o(rdata_a0),
    .raddr_b_i(cnt_q),
    .rdata_b_o(rdata_b0)
  );

  eq_coeff_bank #(
    .Depth(NrEqCoeff),
    .Width(W),
    .AddrW(AW)
  ) u_bank1 (
    .clk_i    (clk_i),
    .we_i     (bank1_we),
    .waddr_i  (bank_waddr),
    .wdata_i  (bank_wdata),
    .raddr_a_i(eq_coeff_addr_i),
    .rdata_a_o(rdata_a1),
    .raddr_b_i(cnt_q),
    .rdata_b_o(rdata_b1)
  );

endmodule
